// File: rtl/uart_frame_packetizer.sv
// Captures FRAME_LEN samples after a Start pulse and sends them as a framed UART byte packet.
// Optional feature: define PACKETIZER_CHECKSUM_EN to append an XOR checksum byte after the payload.
module uart_frame_packetizer #(
  parameter int          FRAME_LEN    = 32,
  parameter int          SAMPLE_W     = 10,
  parameter logic [7:0]  HEADER       = 8'hA5,
  parameter int          BUSY_TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Start,
  input  logic [SAMPLE_W-1:0] Sample_in,
  input  logic                Sample_valid,
  output logic                Sample_ready,
  input  logic                Tx_Ready,
  output logic [7:0]          Word_To_Send,
  output logic                TX_Write_en,
  output logic                TX_en,
  output logic                Busy,
  output logic                Frame_Done,
  output logic                Tx_Error,
  output logic                Start_Dropped
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int DEPTH = 1 << IDX_W;
  localparam int TMO_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT + 1) : 1;

  localparam logic [7:0]       LEN_BYTE = 8'(2 * FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_WR  = IDX_W'(FRAME_LEN - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);
`ifdef PACKETIZER_CHECKSUM_EN
  localparam logic [8:0]       LAST_IDX = 9'(2 * FRAME_LEN + 2);
`else
  localparam logic [8:0]       LAST_IDX = 9'(2 * FRAME_LEN + 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    wr_ptr;
  logic [IDX_W-1:0]    rd_ptr;
  logic                lo_sel;
  logic [8:0]          byte_idx;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [SAMPLE_W-1:0] buffer [DEPTH];
  logic [15:0]         sample_word;
  logic [7:0]          cur_byte;
`ifdef PACKETIZER_CHECKSUM_EN
  logic [7:0]          checksum;
`endif

  // Start is refused combinationally so the drop is flagged in the same cycle it arrives.
  assign Start_Dropped = Start && Busy;

  // NOTE: every variable driven here gets a default first, so no latch is inferred.
  always_comb begin
    sample_word = 16'(buffer[rd_ptr]);
    cur_byte    = lo_sel ? sample_word[7:0] : sample_word[15:8];
    if (byte_idx == 9'd0) begin
      cur_byte = HEADER;
    end else if (byte_idx == 9'd1) begin
      cur_byte = LEN_BYTE;
    end
`ifdef PACKETIZER_CHECKSUM_EN
    else if (byte_idx == LAST_IDX) begin
      cur_byte = checksum;
    end
`endif
  end

  // NOTE: the sample buffer is plain storage and deliberately has no reset; only pointers do.
  always_ff @(posedge clk) begin
    if (state == S_FILL && Sample_valid && Sample_ready) begin
      buffer[wr_ptr] <= Sample_in;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      lo_sel       <= 1'b0;
      byte_idx     <= '0;
      tmo_cnt      <= '0;
      Sample_ready <= 1'b0;
      Word_To_Send <= '0;
      TX_Write_en  <= 1'b0;
      TX_en        <= 1'b0;
      Busy         <= 1'b0;
      Frame_Done   <= 1'b0;
      Tx_Error     <= 1'b0;
`ifdef PACKETIZER_CHECKSUM_EN
      checksum     <= '0;
`endif
    end else begin
      TX_Write_en <= 1'b0;
      TX_en       <= 1'b0;
      Frame_Done  <= 1'b0;
      Tx_Error    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            state        <= S_FILL;
            Busy         <= 1'b1;
            Sample_ready <= 1'b1;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            lo_sel       <= 1'b0;
            byte_idx     <= '0;
`ifdef PACKETIZER_CHECKSUM_EN
            checksum     <= '0;
`endif
          end
        end
        S_FILL: begin
          if (Sample_valid && Sample_ready) begin
            if (wr_ptr == LAST_WR) begin
              Sample_ready <= 1'b0;
              state        <= S_ISSUE;
            end else begin
              wr_ptr <= wr_ptr + IDX_W'(1);
            end
          end
        end
        S_ISSUE: begin
          if (Tx_Ready) begin
            Word_To_Send <= cur_byte;
            TX_Write_en  <= 1'b1;
            TX_en        <= 1'b1;
            tmo_cnt      <= '0;
            state        <= S_WAIT_BUSY;
`ifdef PACKETIZER_CHECKSUM_EN
            // HEADER and the checksum byte itself stay out of the running XOR.
            if (byte_idx != 9'd0 && byte_idx != LAST_IDX) begin
              checksum <= checksum ^ cur_byte;
            end
`endif
          end
        end
        S_WAIT_BUSY: begin
          if (!Tx_Ready) begin
            state <= S_WAIT_DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            Tx_Error <= 1'b1;
            Busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (Tx_Ready) begin
            if (byte_idx == LAST_IDX) begin
              Frame_Done <= 1'b1;
              Busy       <= 1'b0;
              state      <= S_IDLE;
            end else begin
              byte_idx <= byte_idx + 9'd1;
              state    <= S_ISSUE;
              if (byte_idx >= 9'd2) begin
                lo_sel <= ~lo_sel;
                if (lo_sel) begin
                  rd_ptr <= rd_ptr + IDX_W'(1);
                end
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_packetizer.sv
// Self-checking bench for uart_frame_packetizer: table-driven packets, a byte scoreboard and a UART model.
// Works with or without PACKETIZER_CHECKSUM_EN defined.
module tb_uart_frame_packetizer;

  localparam int         FRAME_LEN    = 2;
  localparam int         SAMPLE_W     = 10;
  localparam logic [7:0] HEADER       = 8'hA5;
  localparam int         BUSY_TIMEOUT = 15;
`ifdef PACKETIZER_CHECKSUM_EN
  localparam int         NBYTES       = 3 + 2 * FRAME_LEN;
`else
  localparam int         NBYTES       = 2 + 2 * FRAME_LEN;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                Start;
  logic [SAMPLE_W-1:0] Sample_in;
  logic                Sample_valid;
  logic                Sample_ready;
  logic                Tx_Ready = 1'b1;
  logic [7:0]          Word_To_Send;
  logic                TX_Write_en;
  logic                TX_en;
  logic                Busy;
  logic                Frame_Done;
  logic                Tx_Error;
  logic                Start_Dropped;

  uart_frame_packetizer #(
    .FRAME_LEN    (FRAME_LEN),
    .SAMPLE_W     (SAMPLE_W),
    .HEADER       (HEADER),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .Start         (Start),
    .Sample_in     (Sample_in),
    .Sample_valid  (Sample_valid),
    .Sample_ready  (Sample_ready),
    .Tx_Ready      (Tx_Ready),
    .Word_To_Send  (Word_To_Send),
    .TX_Write_en   (TX_Write_en),
    .TX_en         (TX_en),
    .Busy          (Busy),
    .Frame_Done    (Frame_Done),
    .Tx_Error      (Tx_Error),
    .Start_Dropped (Start_Dropped)
  );

  // One packet: two samples, valid gap cycles between them, and the hand-computed checksum byte.
  typedef struct {
    logic [9:0] s0;
    logic [9:0] s1;
    int         gap;
    logic [7:0] chk;
  } vec_t;

  vec_t       vecs [4];
  logic [7:0] exp_q [$];
  logic [7:0] last_byte;
  int n_checks    = 0;
  int n_err       = 0;
  int cyc         = 0;
  int strobes     = 0;
  int frame_dones = 0;
  int tx_errors   = 0;
  int accepts     = 0;
  int strobe_cyc  = 0;
  int err_cyc     = 0;
  int uart_cnt    = 0;
  bit uart_stuck  = 1'b0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (Sample_valid === 1'b1 && Sample_ready === 1'b1) accepts++;
  end

  // UART model and byte scoreboard: drops Tx_Ready 2 cycles after a strobe, raises it 20 cycles later.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      Tx_Ready = 1'b1;
      uart_cnt = 0;
    end else begin
      if (TX_Write_en === 1'b1) begin
        strobes++;
        strobe_cyc = cyc;
        last_byte  = Word_To_Send;
        check("tx_en_with_write", {31'd0, TX_en}, 32'd1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL extra_strobe: got byte %0h, expected no strobe", Word_To_Send);
        end else begin
          check("byte", {24'd0, Word_To_Send}, {24'd0, exp_q.pop_front()});
        end
        if (!uart_stuck) uart_cnt = 1;
      end else if (uart_cnt > 0) begin
        check("word_stable", {24'd0, Word_To_Send}, {24'd0, last_byte});
        uart_cnt++;
        if (uart_cnt == 3) Tx_Ready = 1'b0;
        if (uart_cnt == 23) begin
          Tx_Ready = 1'b1;
          uart_cnt = 0;
        end
      end
      if (Frame_Done === 1'b1) frame_dones++;
      if (Tx_Error === 1'b1) begin
        tx_errors++;
        err_cyc = cyc;
      end
    end
  end

  task automatic feed(input logic [9:0] s, input int gap);
    Sample_in    = s;
    Sample_valid = 1'b1;
    for (int t = 0; t < 50 && Sample_ready !== 1'b1; t++) @(negedge clk);
    @(negedge clk);
    Sample_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic start_fill(input vec_t v);
    int a0;
    a0 = accepts;
    @(negedge clk);
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    check("busy_after_start", {31'd0, Busy}, 32'd1);
    exp_q.push_back(HEADER);
    exp_q.push_back(8'(2 * FRAME_LEN));
    exp_q.push_back({6'd0, v.s0[9:8]});
    exp_q.push_back(v.s0[7:0]);
    exp_q.push_back({6'd0, v.s1[9:8]});
    exp_q.push_back(v.s1[7:0]);
`ifdef PACKETIZER_CHECKSUM_EN
    exp_q.push_back(v.chk);
`endif
    feed(v.s0, v.gap);
    feed(v.s1, v.gap);
    check("ready_low_after_last", {31'd0, Sample_ready}, 32'd0);
    // Extra valid cycles with junk data must not be accepted.
    Sample_in    = 10'h2DB;
    Sample_valid = 1'b1;
    repeat (3) @(negedge clk);
    Sample_valid = 1'b0;
    check("accept_count", 32'(accepts - a0), 32'(FRAME_LEN));
  endtask

  task automatic wait_done(input int s0, input int f0);
    for (int t = 0; t < 3000 && frame_dones == f0; t++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("frame_done_once", 32'(frame_dones - f0), 32'd1);
    check("strobe_count", 32'(strobes - s0), 32'(NBYTES));
    check("busy_clear", {31'd0, Busy}, 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, f, e;
    vecs[0] = '{10'h3FF, 10'h001, 0, 8'hF9};
    vecs[1] = '{10'h155, 10'h2AA, 1, 8'hF8};
    vecs[2] = '{10'h000, 10'h000, 0, 8'h04};
    vecs[3] = '{10'h123, 10'h3C0, 1, 8'hE5};

    reset        = 1'b1;
    Start        = 1'b0;
    Sample_valid = 1'b0;
    Sample_in    = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",          {31'd0, Busy},          32'd0);
    check("rst_sample_ready",  {31'd0, Sample_ready},  32'd0);
    check("rst_write_en",      {31'd0, TX_Write_en},   32'd0);
    check("rst_tx_en",         {31'd0, TX_en},         32'd0);
    check("rst_word",          {24'd0, Word_To_Send},  32'd0);
    check("rst_frame_done",    {31'd0, Frame_Done},    32'd0);
    check("rst_tx_error",      {31'd0, Tx_Error},      32'd0);
    check("rst_start_dropped", {31'd0, Start_Dropped}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven packets.
    for (int i = 0; i < 4; i++) begin
      s = strobes;
      f = frame_dones;
      start_fill(vecs[i]);
      wait_done(s, f);
    end

    // Start pulsed mid-packet is dropped and the packet is unaffected.
    s = strobes;
    f = frame_dones;
    start_fill(vecs[3]);
    for (int t = 0; t < 500 && strobes < s + 3; t++) @(negedge clk);
    @(negedge clk);
    Start = 1'b1;
    #1;
    check("start_dropped", {31'd0, Start_Dropped}, 32'd1);
    check("busy_mid_packet", {31'd0, Busy}, 32'd1);
    @(negedge clk);
    Start = 1'b0;
    #1;
    check("start_dropped_clear", {31'd0, Start_Dropped}, 32'd0);
    wait_done(s, f);

    // UART never goes busy: handshake timeout.
    uart_stuck = 1'b1;
    s = strobes;
    e = tx_errors;
    f = frame_dones;
    start_fill(vecs[0]);
    for (int t = 0; t < 500 && tx_errors == e; t++) @(negedge clk);
    check("tx_error_seen", 32'(tx_errors - e), 32'd1);
    check("tmo_window", {31'd0, (err_cyc - strobe_cyc >= 15) && (err_cyc - strobe_cyc <= 17)}, 32'd1);
    check("busy_after_tmo", {31'd0, Busy}, 32'd0);
    repeat (40) @(negedge clk);
    check("strobes_after_tmo", 32'(strobes - s), 32'd1);
    check("tx_error_once", 32'(tx_errors - e), 32'd1);
    check("no_done_after_tmo", 32'(frame_dones - f), 32'd0);
    exp_q.delete();
    uart_stuck = 1'b0;

    // Asynchronous reset while payload byte 3 is being strobed.
    s = strobes;
    start_fill(vecs[1]);
    for (int t = 0; t < 500 && strobes < s + 5; t++) begin
      @(negedge clk);
      #2;
    end
    check("strobe_before_reset", {31'd0, TX_Write_en}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_write_en", {31'd0, TX_Write_en}, 32'd0);
    check("async_tx_en",    {31'd0, TX_en},       32'd0);
    check("async_busy",     {31'd0, Busy},        32'd0);
    check("async_word",     {24'd0, Word_To_Send}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);

    s = strobes;
    f = frame_dones;
    start_fill(vecs[0]);
    wait_done(s, f);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
